// File: rtl/storage_arbiter.sv
`timescale 1ns/1ps
// Arbitrates NUM_REQ requesters onto the single storage_controller port, with a one-cycle
// gap between accesses and a timeout abort. Define STORAGE_ARB_ROUND_ROBIN_EN for round-robin.
module storage_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  prog_mode,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ*32-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0] req_wdata,
    input  logic [NUM_REQ*4-1:0]  req_be,
    output logic [NUM_REQ-1:0]    req_done,
    output logic                  req_err,
    output logic [31:0]           req_rdata,
    output logic                  busy,
    output logic                  memory_access,
    output logic                  memory_is_writing,
    output logic [31:0]           addr,
    output logic [31:0]           d_in,
    output logic [3:0]            mem_be,
    input  logic [31:0]           d_out,
    input  logic                  out_valid
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             state_r;
    logic [TO_W-1:0]    cnt_r;
    logic [IDX_W-1:0]   grant_r;
    logic [IDX_W-1:0]   win_idx_s;
    logic [IDX_W-1:0]   cand_s;
    logic               win_found_s;
    logic [31:0]        addr_arr_s  [NUM_REQ];
    logic [31:0]        wdata_arr_s [NUM_REQ];
    logic [3:0]         be_arr_s    [NUM_REQ];
`ifdef STORAGE_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]   ptr_r;
`endif

    // Unpack the flat request buses into per-requester arrays
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_arr_s[i]  = req_addr[32*i +: 32];
            wdata_arr_s[i] = req_wdata[32*i +: 32];
            be_arr_s[i]    = req_be[4*i +: 4];
        end
    end

    // Winner search: upward from the pointer in round-robin mode, from index 0 otherwise
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        cand_s      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef STORAGE_ARB_ROUND_ROBIN_EN
            cand_s = IDX_W'((int'(ptr_r) + 1 + i) % NUM_REQ);
`else
            cand_s = IDX_W'(i);
`endif
            if (!win_found_s && req_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Arbiter FSM with registered controller-side and requester-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= ST_IDLE;
            cnt_r             <= '0;
            grant_r           <= '0;
            memory_access     <= 1'b0;
            memory_is_writing <= 1'b0;
            addr              <= 32'h0000_0000;
            d_in              <= 32'h0000_0000;
            mem_be            <= 4'h0;
            req_done          <= '0;
            req_err           <= 1'b0;
            req_rdata         <= 32'h0000_0000;
            busy              <= 1'b0;
`ifdef STORAGE_ARB_ROUND_ROBIN_EN
            ptr_r             <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!prog_mode && win_found_s) begin
                        state_r           <= ST_BUSY;
                        grant_r           <= win_idx_s;
                        cnt_r             <= '0;
                        memory_access     <= 1'b1;
                        memory_is_writing <= req_we[win_idx_s];
                        addr              <= addr_arr_s[win_idx_s];
                        d_in              <= wdata_arr_s[win_idx_s];
                        mem_be            <= be_arr_s[win_idx_s];
                        busy              <= 1'b1;
`ifdef STORAGE_ARB_ROUND_ROBIN_EN
                        ptr_r             <= win_idx_s;
`endif
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Completion and timeout share one exit; out_valid takes precedence
                    if (out_valid || (cnt_r == TO_LAST)) begin
                        state_r           <= ST_GAP;
                        req_done          <= NUM_REQ'(1'b1) << grant_r;
                        req_err           <= ~out_valid;
                        if (!out_valid) begin
                            req_rdata <= 32'h0000_0000;
                        end else if (!memory_is_writing) begin
                            req_rdata <= d_out;
                        end else begin
                            req_rdata <= req_rdata;
                        end
                        memory_access     <= 1'b0;
                        memory_is_writing <= 1'b0;
                        addr              <= 32'h0000_0000;
                        d_in              <= 32'h0000_0000;
                        mem_be            <= 4'h0;
                    end else begin
                        cnt_r <= cnt_r + TO_W'(1);
                    end
                end
                ST_GAP: begin
                    state_r  <= ST_IDLE;
                    req_done <= '0;
                    req_err  <= 1'b0;
                    cnt_r    <= '0;
                    busy     <= 1'b0;
                end
                default: begin
                    state_r           <= ST_IDLE;
                    cnt_r             <= '0;
                    memory_access     <= 1'b0;
                    memory_is_writing <= 1'b0;
                    addr              <= 32'h0000_0000;
                    d_in              <= 32'h0000_0000;
                    mem_be            <= 4'h0;
                    req_done          <= '0;
                    req_err           <= 1'b0;
                    busy              <= 1'b0;
                end
            endcase
        end
    end

endmodule
